// File: rtl/mem_arbiter_if.sv
// Bundle of fetcher, writer and SDRAM-controller command signals around mem_arbiter.
// master = arbiter side, slave = clients and controller side.
interface mem_arbiter_if #(
   parameter int AW = 25,
   parameter int DW = 16
);
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_ack;
   logic          rd_data_valid;
   logic [DW-1:0] rd_data;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ack;
   logic          wr_idle;
   logic          ctl_req;
   logic          ctl_we;
   logic [AW-1:0] ctl_addr;
   logic [DW-1:0] ctl_wdata;
   logic [7:0]    ctl_len;
   logic          ctl_ack;
   logic          ctl_rdata_valid;
   logic [DW-1:0] ctl_rdata;
   logic          err;

   modport master (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
             ctl_ack, ctl_rdata_valid, ctl_rdata,
      output rd_ack, rd_data_valid, rd_data, wr_ack, wr_idle,
             ctl_req, ctl_we, ctl_addr, ctl_wdata, ctl_len, err
   );

   modport slave (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data,
             ctl_ack, ctl_rdata_valid, ctl_rdata,
      input  rd_ack, rd_data_valid, rd_data, wr_ack, wr_idle,
             ctl_req, ctl_we, ctl_addr, ctl_wdata, ctl_len, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Read-priority arbiter between the pixel writer and the line fetcher onto one SDRAM command port.
// A consecutive-read limit guarantees the writer forward progress.
module mem_arbiter #(
   parameter int AW            = 25,
   parameter int DW            = 16,
   parameter int RD_BURST      = 128,
   parameter int MAX_RD_CONSEC = 4
) (
   input  logic          mem_clk,
   input  logic          rst_n,
   mem_arbiter_if.master bus
);

   typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_CMD} state_e;

   state_e        state_q, state_d;
   logic          ctl_req_q, ctl_req_d;
   logic          ctl_we_q, ctl_we_d;
   logic [AW-1:0] ctl_addr_q, ctl_addr_d;
   logic [DW-1:0] ctl_wdata_q, ctl_wdata_d;
   logic [7:0]    ctl_len_q, ctl_len_d;
   logic          rd_ack_q, rd_ack_d;
   logic          rd_data_valid_q, rd_data_valid_d;
   logic [DW-1:0] rd_data_q, rd_data_d;
   logic [3:0]    rd_streak_q, rd_streak_d;
   logic [7:0]    beat_cnt_q, beat_cnt_d;
   logic          err_q, err_d;
   logic          rd_sel;

   always_comb begin
      state_d         = state_q;
      ctl_req_d       = ctl_req_q;
      ctl_we_d        = ctl_we_q;
      ctl_addr_d      = ctl_addr_q;
      ctl_wdata_d     = ctl_wdata_q;
      ctl_len_d       = ctl_len_q;
      rd_ack_d        = 1'b0;
      rd_data_valid_d = 1'b0;
      rd_data_d       = rd_data_q;
      rd_streak_d     = rd_streak_q;
      beat_cnt_d      = beat_cnt_q;
      err_d           = err_q;
      // a pending write only blocks reads once the streak hits the limit
      rd_sel = bus.rd_req && (!bus.wr_req || (rd_streak_q < 4'(MAX_RD_CONSEC)));

      case (state_q)
         IDLE: begin
            if (bus.ctl_ack || bus.ctl_rdata_valid) err_d = 1'b1;
            if (rd_sel) begin
               state_d     = RD_CMD;
               ctl_req_d   = 1'b1;
               ctl_we_d    = 1'b0;
               ctl_addr_d  = bus.rd_addr;
               ctl_wdata_d = '0;
               ctl_len_d   = 8'(RD_BURST);
               if (!bus.wr_req)
                  rd_streak_d = '0;
               else if (rd_streak_q >= 4'(MAX_RD_CONSEC))
                  rd_streak_d = 4'(MAX_RD_CONSEC);
               else
                  rd_streak_d = rd_streak_q + 4'd1;
            end else if (bus.wr_req) begin
               state_d     = WR_CMD;
               ctl_req_d   = 1'b1;
               ctl_we_d    = 1'b1;
               ctl_addr_d  = bus.wr_addr;
               ctl_wdata_d = bus.wr_data;
               ctl_len_d   = 8'd1;
               rd_streak_d = '0;
            end
         end
         RD_CMD: begin
            if (bus.ctl_rdata_valid) err_d = 1'b1;
            if (bus.ctl_ack) begin
               state_d    = RD_DATA;
               ctl_req_d  = 1'b0;
               rd_ack_d   = 1'b1;
               beat_cnt_d = 8'(RD_BURST);
            end
         end
         RD_DATA: begin
            if (bus.ctl_ack) err_d = 1'b1;
            if (bus.ctl_rdata_valid) begin
               rd_data_valid_d = 1'b1;
               rd_data_d       = bus.ctl_rdata;
               beat_cnt_d      = beat_cnt_q - 8'd1;
               if (beat_cnt_q == 8'd1) state_d = IDLE;
            end
         end
         WR_CMD: begin
            if (bus.ctl_rdata_valid) err_d = 1'b1;
            if (bus.ctl_ack) begin
               state_d   = IDLE;
               ctl_req_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         ctl_req_q       <= 1'b0;
         ctl_we_q        <= 1'b0;
         ctl_addr_q      <= '0;
         ctl_wdata_q     <= '0;
         ctl_len_q       <= '0;
         rd_ack_q        <= 1'b0;
         rd_data_valid_q <= 1'b0;
         rd_data_q       <= '0;
         rd_streak_q     <= '0;
         beat_cnt_q      <= '0;
         err_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         ctl_req_q       <= ctl_req_d;
         ctl_we_q        <= ctl_we_d;
         ctl_addr_q      <= ctl_addr_d;
         ctl_wdata_q     <= ctl_wdata_d;
         ctl_len_q       <= ctl_len_d;
         rd_ack_q        <= rd_ack_d;
         rd_data_valid_q <= rd_data_valid_d;
         rd_data_q       <= rd_data_d;
         rd_streak_q     <= rd_streak_d;
         beat_cnt_q      <= beat_cnt_d;
         err_q           <= err_d;
      end
   end

   assign bus.ctl_req       = ctl_req_q;
   assign bus.ctl_we        = ctl_we_q;
   assign bus.ctl_addr      = ctl_addr_q;
   assign bus.ctl_wdata     = ctl_wdata_q;
   assign bus.ctl_len       = ctl_len_q;
   assign bus.rd_ack        = rd_ack_q;
   assign bus.rd_data_valid = rd_data_valid_q;
   assign bus.rd_data       = rd_data_q;
   assign bus.err           = err_q;
   assign bus.wr_idle       = (state_q == IDLE);
   assign bus.wr_ack        = bus.ctl_ack && (state_q == WR_CMD);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected commands and read beats,
// an independent monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

   typedef struct packed {
      logic        we;
      logic [24:0] addr;
      logic [15:0] wdata;
      logic [7:0]  len;
   } cmd_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   rd_ack_cnt;
   int   wr_ack_cnt;
   cmd_t        exp_cmd[$];
   logic [15:0] exp_rd[$];

   mem_arbiter_if #(.AW(25), .DW(16)) bus ();

   mem_arbiter #(.AW(25), .DW(16), .RD_BURST(128), .MAX_RD_CONSEC(4)) dut (
      .mem_clk (clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // monitor: command issue, read beats (with 1-cycle lag), ack pulse counts
   initial begin
      logic prev_req;
      logic prev_in_v;
      cmd_t c;
      cmd_t a;
      logic [15:0] e;
      prev_req  = 1'b0;
      prev_in_v = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_req  = 1'b0;
            prev_in_v = 1'b0;
         end else begin
            if (bus.ctl_req && !prev_req) begin
               chk("cmd_expected", exp_cmd.size() != 0, 1'b1);
               if (exp_cmd.size() != 0) begin
                  c = exp_cmd.pop_front();
                  a = '{we: bus.ctl_we, addr: bus.ctl_addr,
                        wdata: (bus.ctl_we ? bus.ctl_wdata : 16'h0), len: bus.ctl_len};
                  chk("cmd_fields", 64'(a), 64'(c));
               end
            end
            prev_req = bus.ctl_req;
            if (bus.rd_data_valid) begin
               chk("rd_beat_expected", exp_rd.size() != 0, 1'b1);
               if (exp_rd.size() != 0) begin
                  e = exp_rd.pop_front();
                  chk("rd_beat_data_lag", {prev_in_v, bus.rd_data}, {1'b1, e});
               end
            end
            prev_in_v = bus.ctl_rdata_valid;
            if (bus.rd_ack) rd_ack_cnt++;
            if (bus.wr_ack) wr_ack_cnt++;
         end
      end
   end

   task automatic wait_req();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (bus.ctl_req) begin
            ok = 1'b1;
            break;
         end
      end
      chk("ctl_req_within_budget", ok, 1'b1);
   endtask

   task automatic run_beats(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         if (i % 5 == 3) begin
            bus.ctl_rdata_valid = 1'b0;
            @(posedge clk); #1;
         end
         bus.ctl_rdata_valid = 1'b1;
         bus.ctl_rdata       = 16'(base + i);
         exp_rd.push_back(16'(base + i));
         @(posedge clk); #1;
         if (i == n / 2) chk("rd_wr_idle_low", bus.wr_idle, 1'b0);
      end
      bus.ctl_rdata_valid = 1'b0;
   endtask

   task automatic do_write(input logic [24:0] addr, input logic [15:0] data);
      exp_cmd.push_back('{we: 1'b1, addr: addr, wdata: data, len: 8'd1});
      bus.wr_req  = 1'b1;
      bus.wr_addr = addr;
      bus.wr_data = data;
      wait_req();
      chk("wr_idle_low_in_cmd", bus.wr_idle, 1'b0);
      bus.ctl_ack = 1'b1;
      #1;
      chk("wr_ack_same_cycle", bus.wr_ack, 1'b1);
      @(posedge clk); #1;
      bus.ctl_ack = 1'b0;
      bus.wr_req  = 1'b0;
      chk("wr_back_idle", {bus.wr_idle, bus.ctl_req, bus.wr_ack}, 3'b100);
   endtask

   task automatic read_cmd(input logic [24:0] addr, input int ack_delay);
      exp_cmd.push_back('{we: 1'b0, addr: addr, wdata: 16'h0, len: 8'd128});
      bus.rd_req  = 1'b1;
      bus.rd_addr = addr;
      wait_req();
      for (int i = 0; i < ack_delay; i++) begin
         @(posedge clk); #1;
      end
      chk("rd_cmd_held", {bus.ctl_req, bus.ctl_addr}, {1'b1, addr});
      bus.ctl_ack = 1'b1;
      @(posedge clk); #1;
      bus.ctl_ack = 1'b0;
      bus.rd_req  = 1'b0;
      chk("rd_ack_pulse_req_drop", {bus.rd_ack, bus.ctl_req}, 2'b10);
   endtask

   task automatic chk_reset_outs(input string name);
      chk(name, {bus.wr_idle,
                 |{bus.ctl_req, bus.ctl_we, bus.rd_ack, bus.rd_data_valid, bus.wr_ack,
                   bus.err, bus.ctl_len, bus.ctl_addr, bus.ctl_wdata, bus.rd_data}}, 2'b10);
   endtask

   initial begin
      checks = 0; failures = 0; rd_ack_cnt = 0; wr_ack_cnt = 0;
      rst_n = 1'b0;
      bus.rd_req = 1'b0; bus.rd_addr = '0;
      bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.ctl_ack = 1'b0; bus.ctl_rdata_valid = 1'b0; bus.ctl_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outs("reset_state");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single write
      do_write(25'h000010, 16'hBEEF);

      // single read burst, ack after 3 cycles, beats 0..127 with gaps
      read_cmd(25'h001000, 3);
      run_beats(128, 0);
      chk("rd_last_beat_with_idle", {bus.wr_idle, bus.rd_data_valid, bus.rd_data}, {2'b11, 16'd127});
      chk("rd_no_err", bus.err, 1'b0);

      // write arriving during RD_DATA waits for IDLE
      read_cmd(25'h002000, 0);
      bus.wr_req  = 1'b1;
      bus.wr_addr = 25'h000020;
      bus.wr_data = 16'h1234;
      exp_cmd.push_back('{we: 1'b1, addr: 25'h000020, wdata: 16'h1234, len: 8'd1});
      run_beats(128, 16'h4000);
      chk("late_idle_no_req", {bus.wr_idle, bus.ctl_req}, 2'b10);
      @(posedge clk); #1;
      chk("late_ctl_req_rise", {bus.ctl_req, bus.ctl_we}, 2'b11);
      bus.ctl_ack = 1'b1;
      #1;
      chk("late_wr_ack", bus.wr_ack, 1'b1);
      @(posedge clk); #1;
      bus.ctl_ack = 1'b0;
      bus.wr_req  = 1'b0;

      // starvation guard: both requests held, expect R,R,R,R,W,R,R,R,R,W
      for (int k = 0; k < 10; k++) begin
         if (k == 4 || k == 9)
            exp_cmd.push_back('{we: 1'b1, addr: 25'h000040, wdata: 16'h5555, len: 8'd1});
         else
            exp_cmd.push_back('{we: 1'b0, addr: 25'h003000, wdata: 16'h0, len: 8'd128});
      end
      bus.rd_req = 1'b1; bus.rd_addr = 25'h003000;
      bus.wr_req = 1'b1; bus.wr_addr = 25'h000040; bus.wr_data = 16'h5555;
      for (int k = 0; k < 10; k++) begin
         wait_req();
         bus.ctl_ack = 1'b1;
         if (bus.ctl_we) begin
            @(posedge clk); #1;
            bus.ctl_ack = 1'b0;
            if (k == 9) begin
               bus.wr_req = 1'b0;
               bus.rd_req = 1'b0;
            end
         end else begin
            @(posedge clk); #1;
            bus.ctl_ack = 1'b0;
            run_beats(128, k * 256);
         end
      end
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;

      // reset in the middle of a burst, then a fresh write
      read_cmd(25'h005000, 1);
      run_beats(50, 16'h6000);
      rst_n = 1'b0;
      #1;
      exp_rd.delete();
      chk_reset_outs("reset_mid_burst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("post_reset_err_clear", bus.err, 1'b0);
      @(posedge clk); #1;
      do_write(25'h000077, 16'hCAFE);
      chk("post_reset_write_no_err", bus.err, 1'b0);

      // stray ctl_ack in IDLE
      bus.ctl_ack = 1'b1;
      #1;
      chk("stray_ack_no_wr_ack", bus.wr_ack, 1'b0);
      @(posedge clk); #1;
      bus.ctl_ack = 1'b0;
      chk("stray_ack_err", {bus.err, bus.wr_idle, bus.ctl_req}, 3'b110);

      // stray read beat in IDLE
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("stray_beat_pre_err", bus.err, 1'b0);
      bus.ctl_rdata_valid = 1'b1;
      bus.ctl_rdata = 16'hDEAD;
      @(posedge clk); #1;
      bus.ctl_rdata_valid = 1'b0;
      chk("stray_beat_dropped", {bus.rd_data_valid, bus.err}, 2'b01);
      repeat (3) @(posedge clk);
      #1;
      chk("err_sticky", bus.err, 1'b1);

      @(negedge clk); #1;
      chk("cmd_queue_drained", exp_cmd.size(), 0);
      chk("rd_queue_drained", exp_rd.size(), 0);
      chk("rd_ack_count", rd_ack_cnt, 11);
      chk("wr_ack_count", wr_ack_cnt, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the FTDI pixel writer (single-word writes) and the video line fetcher (fixed-length read bursts), driving one command port of the SDRAM controller. Sits in the `mem_clk` domain. It replaces the direct writer-to-controller connection and supplies the writer's idle and ack signals. Reads have priority. A consecutive-read limit guarantees the writer forward progress.

## Interface
- `AW`, 25, address width in words.
- `DW`, 16, data width.
- `RD_BURST`, 128, words per read burst; legal range 1..255.
- `MAX_RD_CONSEC`, 4, read grants allowed in a row while a write is pending; legal range 1..15.

Ports:
- `mem_clk`  in  1  sole clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rd_req`  in  1  fetcher requests a burst; held until `rd_ack`.
- `rd_addr`  in  AW  burst start address; stable while `rd_req` is high.
- `rd_ack`  out  1  one-cycle pulse when the burst command is accepted.
- `rd_data_valid`  out  1  one beat of read data.
- `rd_data`  out  DW  read data.
- `wr_req`  in  1  writer request; held until `wr_ack`.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  DW  write data.
- `wr_ack`  out  1  write accepted (combinational: `ctl_ack` and state WR_CMD).
- `wr_idle`  out  1  high when state is IDLE; the writer uses it to gate command parsing.
- `ctl_req`  out  1  command valid to the controller.
- `ctl_we`  out  1  1 = write, 0 = read.
- `ctl_addr`  out  AW  command address.
- `ctl_wdata`  out  DW  write data.
- `ctl_len`  out  8  burst length: `RD_BURST` for reads, 1 for writes.
- `ctl_ack`  in  1  command accepted in this cycle.
- `ctl_rdata_valid`  in  1  controller read beat.
- `ctl_rdata`  in  DW  controller read data.
- `err`  out  1  sticky; cleared only by reset.

## Operation
- **States:** IDLE, RD_CMD, RD_DATA, WR_CMD.
- **IDLE, selection:**
  - Read is selected if `rd_req` is high and (`wr_req` is low or `rd_streak` < `MAX_RD_CONSEC`).
  - Otherwise write is selected if `wr_req` is high.
  - On selection, address, data, `we` and `len` are registered into the `ctl_*` outputs and `ctl_req` is set.
- **RD_CMD:** hold `ctl_req` until `ctl_ack`. On `ctl_ack`: pulse `rd_ack`, drop `ctl_req`, load beat counter = `RD_BURST`, go to RD_DATA.
- **RD_DATA:**
  - Each `ctl_rdata_valid` forwards `ctl_rdata` to `rd_data`/`rd_data_valid` (registered) and decrements the counter.
  - The beat that takes the counter to 0 returns the FSM to IDLE.
- **WR_CMD:** hold until `ctl_ack`. In that cycle `wr_ack` is high; next state is IDLE.
- **`rd_streak` (4-bit):**
  - +1 on each read grant while `wr_req` is high.
  - Cleared on a write grant.
  - Cleared on a read grant while `wr_req` is low.
  - Saturates at `MAX_RD_CONSEC`.
- **Boundary cases:**
  - `ctl_rdata_valid` outside RD_DATA is dropped and sets `err`.
  - `ctl_ack` in IDLE or RD_DATA is ignored and sets `err`.
  - `rd_req` and `wr_req` both high with `rd_streak` = `MAX_RD_CONSEC`: write wins.
  - Requests that rise during a transaction wait for IDLE.
- **Reset:**
  - Asynchronous, any state, → IDLE.
  - All outputs 0 except `wr_idle` = 1; `rd_streak` = 0, counter = 0, `err` = 0.
  - Beats in flight when reset releases hit IDLE and set `err`.

## Timing
- Request high in IDLE at edge N → `ctl_req` high after edge N; `wr_idle` low from the same edge.
- `ctl_*` fields are stable from `ctl_req` rising until the `ctl_ack` cycle.
- `ctl_req` is low in the cycle after `ctl_ack`.
- Minimum write spacing is 3 cycles: IDLE, WR_CMD (with same-cycle ack), IDLE.
- The writer sees `wr_ack` in the same cycle as `ctl_ack`. It drops `wr_req` at that edge, so there is no double issue.
- `rd_ack` is a registered pulse in the cycle after `ctl_ack`.
- `rd_data_valid` lags `ctl_rdata_valid` by exactly 1 cycle; data is unmodified and in order.
- FSM returns to IDLE at the edge that registers the last beat. That last `rd_data_valid` coincides with `wr_idle` going high.

## Test plan
- **Single write:** `wr_req`, addr 0x000010, data 0xBEEF, `ctl_ack` in the first WR_CMD cycle → `ctl_we`=1, `ctl_len`=1, `ctl_addr`=0x10, `ctl_wdata`=0xBEEF; `wr_ack` for 1 cycle; IDLE 1 cycle later.
- **Single read burst:** `rd_req`, addr 0x1000, `ctl_ack` delayed 3 cycles, 128 beats 0..127 with gaps → `rd_ack` once; 128 `rd_data_valid` beats 0..127, each 1 cycle after its input; `wr_idle` low throughout.
- **Starvation guard:** `rd_req` and `wr_req` high continuously, `MAX_RD_CONSEC`=4 → grant order R,R,R,R,W,R,R,R,R,W.
- **Protocol errors:** stray `ctl_rdata_valid` in IDLE → `err`=1 and stays 1; no `rd_data_valid`.
- **Reset mid-burst:** `rst_n` low after 50 of 128 beats → all outputs 0, `wr_idle`=1 immediately; after release a fresh write completes normally.
- **Late request:** write arrives during RD_DATA → waits; `ctl_req` for the write rises 1 cycle after the last read beat enters.
